// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - run controller state encoding and default constants
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CORE_RST = 3'd1,
    RUN      = 3'd2,
    DRAIN    = 3'd3,
    FINISH   = 3'd4
  } state_t;

  localparam int DEF_HALT_PC    = 128;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_TIMEOUT    = 4096;

endpackage

// File: rtl/run_ctrl_if.sv
// rtl/run_ctrl_if.sv - host/core handshake bundle between run_ctrl and its parent
interface run_ctrl_if #(
  parameter int D  = 12,
  parameter int CW = 16
);

  logic          req;
  logic          abort;
  logic [D-1:0]  prog_ctr;
  logic          core_reset;
  logic          core_en;
  logic          busy;
  logic          done;
  logic          timed_out;
  logic          aborted;
  logic [CW-1:0] cycle_cnt;

  modport master (
    output req, abort, prog_ctr,
    input  core_reset, core_en, busy, done, timed_out, aborted, cycle_cnt
  );

  modport slave (
    input  req, abort, prog_ctr,
    output core_reset, core_en, busy, done, timed_out, aborted, cycle_cnt
  );

endinterface

// File: rtl/run_ctrl_sat_counter.sv
// rtl/run_ctrl_sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - sequences core reset, run, drain and finish for one program run
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int D          = 12,
  parameter int HALT_PC    = DEF_HALT_PC,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CW         = 16
) (
  input logic       clk,
  input logic       reset,
  run_ctrl_if.slave bus
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [D-1:0]  HALT_VAL = D'(HALT_PC);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

  state_t        state;
  logic [RW-1:0] rst_cnt;
  logic          halt;
  logic          to_hit;
  logic          cnt_clr;
  logic          cnt_en;

  assign halt   = (bus.prog_ctr == HALT_VAL);
  assign to_hit = (bus.cycle_cnt == TO_LAST);

  // The cycle that ends RUN (halt, abort or timeout) is not counted.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (state == IDLE && bus.req) begin
      cnt_clr = 1'b1;
    end
    if (state == RUN && !halt && !bus.abort && !to_hit) begin
      cnt_en = 1'b1;
    end
  end

  sat_counter #(
    .W(CW)
  ) u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .count  (bus.cycle_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      rst_cnt        <= '0;
      bus.core_reset <= 1'b1;
      bus.core_en    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.timed_out  <= 1'b0;
      bus.aborted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            state         <= CORE_RST;
            rst_cnt       <= RST_LOAD;
            bus.busy      <= 1'b1;
            bus.timed_out <= 1'b0;
            bus.aborted   <= 1'b0;
          end
        end
        CORE_RST: begin
          if (rst_cnt == '0) begin
            state          <= RUN;
            bus.core_reset <= 1'b0;
            bus.core_en    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        RUN: begin
          // Halt outranks abort, which outranks timeout.
          if (halt) begin
            state       <= DRAIN;
            bus.core_en <= 1'b0;
          end else if (bus.abort) begin
            state       <= FINISH;
            bus.core_en <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.aborted <= 1'b1;
          end else if (to_hit) begin
            state         <= FINISH;
            bus.core_en   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.timed_out <= 1'b1;
          end
        end
        DRAIN: begin
          state    <= FINISH;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        FINISH: begin
          if (!bus.req) begin
            state          <= IDLE;
            bus.done       <= 1'b0;
            bus.core_reset <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          bus.core_reset <= 1'b1;
          bus.core_en    <= 1'b0;
          bus.busy       <= 1'b0;
          bus.done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed self-checking bench for run_ctrl
module tb_run_ctrl;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   n;
  int   runs;

  run_ctrl_if #(.D(12), .CW(16)) bus ();

  run_ctrl #(
    .D          (12),
    .HALT_PC    (128),
    .RST_CYCLES (2),
    .TIMEOUT    (64),
    .CW         (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 32'(bus.core_reset), 1);
    chk({tag, "_core_en"},    32'(bus.core_en),    0);
    chk({tag, "_busy"},       32'(bus.busy),       0);
    chk({tag, "_done"},       32'(bus.done),       0);
    chk({tag, "_timed_out"},  32'(bus.timed_out),  0);
    chk({tag, "_aborted"},    32'(bus.aborted),    0);
    chk({tag, "_cycle_cnt"},  32'(bus.cycle_cnt),  0);
  endtask

  task automatic enter_run();
    bus.req = 1'b1;
    tick();
    ticks(2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.req      = 1'b0;
    bus.abort    = 1'b0;
    bus.prog_ctr = '0;
    ticks(2);
    chk_reset_vals("por");
    reset = 1'b1;
    ticks(2);
    chk("idle_busy", 32'(bus.busy), 0);

    // Run 1: halt after 50 counted RUN cycles
    bus.req = 1'b1;
    tick();
    n = 0;
    while (bus.busy && bus.core_reset && n < 10) begin
      n++;
      tick();
    end
    chk("r1_rst_cycles", 32'(n), 2);
    chk("r1_run_core_en", 32'(bus.core_en), 1);
    chk("r1_run_core_reset", 32'(bus.core_reset), 0);
    for (int i = 0; i < 50; i++) begin
      bus.prog_ctr = 12'(i);
      tick();
    end
    chk("r1_cnt_before_halt", 32'(bus.cycle_cnt), 50);
    bus.prog_ctr = 12'd128;
    tick();
    chk("r1_drain_core_en", 32'(bus.core_en), 0);
    chk("r1_drain_busy", 32'(bus.busy), 1);
    chk("r1_drain_done", 32'(bus.done), 0);
    tick();
    chk("r1_done", 32'(bus.done), 1);
    chk("r1_fin_busy", 32'(bus.busy), 0);
    chk("r1_fin_core_reset", 32'(bus.core_reset), 0);
    chk("r1_cycle_cnt", 32'(bus.cycle_cnt), 50);
    chk("r1_timed_out", 32'(bus.timed_out), 0);
    chk("r1_aborted", 32'(bus.aborted), 0);
    ticks(3);
    chk("r1_done_held_req_high", 32'(bus.done), 1);
    chk("r1_no_restart", 32'(bus.busy), 0);
    bus.req = 1'b0;
    tick();
    chk("r1_done_falls", 32'(bus.done), 0);
    chk("r1_idle_core_reset", 32'(bus.core_reset), 1);
    chk("r1_cnt_held_idle", 32'(bus.cycle_cnt), 50);

    // Run 2: no halt, timeout after 64 RUN cycles
    bus.prog_ctr = '0;
    bus.req = 1'b1;
    tick();
    chk("r2_cnt_cleared", 32'(bus.cycle_cnt), 0);
    chk("r2_busy", 32'(bus.busy), 1);
    ticks(2);
    n = 0;
    runs = 0;
    while (!bus.done && n < 200) begin
      if (bus.core_en) runs++;
      n++;
      tick();
    end
    chk("r2_run_cycles", 32'(runs), 64);
    chk("r2_done", 32'(bus.done), 1);
    chk("r2_timed_out", 32'(bus.timed_out), 1);
    chk("r2_aborted", 32'(bus.aborted), 0);
    chk("r2_cycle_cnt", 32'(bus.cycle_cnt), 63);
    bus.abort = 1'b1;
    tick();
    chk("r2_abort_in_finish", 32'(bus.aborted), 0);
    bus.abort = 1'b0;
    bus.req = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    chk("idle_abort_aborted", 32'(bus.aborted), 0);
    chk("idle_abort_busy", 32'(bus.busy), 0);
    chk("idle_timed_out_held", 32'(bus.timed_out), 1);
    bus.abort = 1'b0;

    // Run 3: abort at RUN cycle 10, req dropped mid-run
    enter_run();
    ticks(5);
    bus.req = 1'b0;
    ticks(5);
    chk("r3_req_drop_busy", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("r3_done", 32'(bus.done), 1);
    chk("r3_aborted", 32'(bus.aborted), 1);
    chk("r3_timed_out", 32'(bus.timed_out), 0);
    chk("r3_cycle_cnt", 32'(bus.cycle_cnt), 10);
    tick();
    chk("r3_back_idle", 32'(bus.done), 0);

    // Run 4: halt and abort together
    enter_run();
    ticks(5);
    bus.prog_ctr = 12'd128;
    bus.abort = 1'b1;
    tick();
    bus.prog_ctr = '0;
    bus.abort = 1'b0;
    chk("r4_drain_busy", 32'(bus.busy), 1);
    chk("r4_drain_done", 32'(bus.done), 0);
    tick();
    chk("r4_done", 32'(bus.done), 1);
    chk("r4_aborted", 32'(bus.aborted), 0);
    chk("r4_cycle_cnt", 32'(bus.cycle_cnt), 5);
    bus.req = 1'b0;
    tick();

    // Run 5: halt and timeout together
    enter_run();
    ticks(63);
    chk("r5_cnt_at_limit", 32'(bus.cycle_cnt), 63);
    bus.prog_ctr = 12'd128;
    tick();
    bus.prog_ctr = '0;
    chk("r5_drain_core_en", 32'(bus.core_en), 0);
    chk("r5_drain_done", 32'(bus.done), 0);
    tick();
    chk("r5_done", 32'(bus.done), 1);
    chk("r5_timed_out", 32'(bus.timed_out), 0);
    chk("r5_cycle_cnt", 32'(bus.cycle_cnt), 63);
    bus.req = 1'b0;
    tick();

    // Run 6: asynchronous reset at RUN cycle 20, then restart
    enter_run();
    ticks(20);
    chk("r6_mid_run_cnt", 32'(bus.cycle_cnt), 20);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    reset = 1'b1;
    tick();
    chk("r6_restart_busy", 32'(bus.busy), 1);
    ticks(2);
    ticks(7);
    bus.prog_ctr = 12'd128;
    n = 0;
    while (!bus.done && n < 20) begin
      n++;
      tick();
    end
    bus.prog_ctr = '0;
    chk("r6_done", 32'(bus.done), 1);
    chk("r6_cycle_cnt", 32'(bus.cycle_cnt), 7);
    bus.req = 1'b0;
    tick();
    chk("r6_idle", 32'(bus.done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter D, default 12, program counter width.
REQ-002 Parameter HALT_PC, default 128, PC value marking program completion.
REQ-003 Parameter RST_CYCLES, default 2, cycles core reset is held after a start.
REQ-004 Parameter TIMEOUT, default 4096, maximum RUN cycles before forced finish.
REQ-005 Parameter CW, default 16, cycle counter width.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 reset  input  1  asynchronous, active-low (0 = reset).
REQ-009 req  input  1  host start request, level; held high until done seen.
REQ-010 abort  input  1  host forced stop, sampled only in RUN.
REQ-011 prog_ctr  input  D  core program counter.
REQ-012 core_reset  output  1  active-high reset to PC/core.
REQ-013 core_en  output  1  core advance enable; 0 stalls PC and all writes.
REQ-014 busy  output  1  high in CORE_RST, RUN, DRAIN.
REQ-015 done  output  1  run complete, level, held until req low.
REQ-016 timed_out  output  1  last run ended by TIMEOUT.
REQ-017 aborted  output  1  last run ended by abort.
REQ-018 cycle_cnt  output  CW  RUN cycles of the current/last run.

Function
REQ-019 FSM states IDLE, CORE_RST, RUN, DRAIN, FINISH; all outputs registered.
REQ-020 IDLE: core_reset=1, core_en=0, done=0; req=1 -> CORE_RST next cycle, clears cycle_cnt, timed_out, aborted.
REQ-021 CORE_RST: core_reset=1, core_en=0 for exactly RST_CYCLES cycles, then RUN.
REQ-022 RUN: core_reset=0, core_en=1; cycle_cnt +1 per cycle, saturating at 2^CW-1.
REQ-023 RUN, prog_ctr==HALT_PC -> DRAIN; that cycle not counted.
REQ-024 RUN, cycle_cnt==TIMEOUT-1 and no halt -> FINISH, timed_out=1.
REQ-025 RUN, abort=1 and no halt -> FINISH, aborted=1.
REQ-026 Same-cycle priority: halt > abort > timeout; only one status flag set per run.
REQ-027 DRAIN: core_en=0 for one cycle so the final memory write commits, then FINISH.
REQ-028 FINISH: done=1, core_en=0, core_reset=0 (core state remains readable); req=0 -> IDLE, done falls on that transition.
REQ-029 req falling during CORE_RST/RUN/DRAIN is ignored; run continues to completion.
REQ-030 req still high on FINISH->IDLE is impossible; a new run requires req low for at least one cycle.
REQ-031 cycle_cnt, timed_out, aborted hold their values in FINISH and IDLE until the next start.
REQ-032 abort outside RUN has no effect.

Reset
REQ-033 reset=0 forces IDLE asynchronously from any state, mid-run included.
REQ-034 Reset values: core_reset=1, core_en=0, busy=0, done=0, timed_out=0, aborted=0, cycle_cnt=0.
REQ-035 Deassertion is synchronised by the parent; the block needs no internal synchroniser.

Structure
REQ-036 Package run_ctrl_pkg holds the state enum and default HALT_PC, RST_CYCLES, TIMEOUT constants.
REQ-037 One sub-module, sat_counter (parameter width, clear, enable, saturate), implements cycle_cnt.
REQ-038 The RST_CYCLES down-counter is inline in the FSM.

Verification
REQ-039 Reset, req=1, prog_ctr reaches 128 after 50 RUN cycles -> core_reset high 2 cycles, done=1, cycle_cnt=50, timed_out=0.
REQ-040 prog_ctr never 128, TIMEOUT=64 -> FINISH after 64 RUN cycles, timed_out=1, cycle_cnt=63.
REQ-041 abort=1 at RUN cycle 10 -> aborted=1, cycle_cnt=10; abort pulsed in IDLE -> no change.
REQ-042 halt and abort in the same cycle -> DRAIN taken, aborted=0; halt and timeout together -> timed_out=0.
REQ-043 reset=0 at RUN cycle 20 -> all outputs at reset values immediately; restart reaches done normally.
REQ-044 req held high after done, then dropped, then raised -> exactly two runs, done low for at least one cycle between.
